// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one single-port synchronous RAM between the CPU
// sequencer and the program loader/debug port using req/ack handshakes.
// Latency: req seen in IDLE -> ack two cycles later; one access per 3 cycles.
// Backpressure: a requester holds req until ack; cpu_wait stalls the sequencer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_* / ld_*        requester ports (req, we, addr, wdata in; rdata, ack out)
//   cpu_wait            cpu_req & ~cpu_ack, combinational stall for the sequencer
//   ld_lock             blocks CPU grants while high
//   gnt_ld              owner of current/last access (1 = loader)
//   mem_*               RAM port; mem_rdata valid one cycle after a read edge
//
// Build option: define MEM_ARB_LD_PRIORITY_EN for fixed loader priority on ties;
// otherwise ties are broken round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    input  logic              ld_lock,
    output logic              gnt_ld,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

    state_t              state_q;
    logic                last_ld_q;
    logic                gnt_ld_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                cpu_ack_q;
    logic                ld_ack_q;
    logic                rd_q;          // current access is a read
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   ld_rdata_q;

    logic                cpu_elig;
    logic                ld_elig;
    logic                grant_ld_d;
    logic                last_ld_d;

    assign cpu_elig = cpu_req & ~ld_lock;
    assign ld_elig  = ld_req;

`ifdef MEM_ARB_LD_PRIORITY_EN
    // Fixed priority: loader wins every tie; the round-robin pointer stays 0.
    assign grant_ld_d = ld_elig;
    assign last_ld_d  = 1'b0;
`else
    // Round robin: on a tie the port that did not win last time goes next.
    assign grant_ld_d = ld_elig & (~cpu_elig | ~last_ld_q);
    assign last_ld_d  = grant_ld_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_ld_q   <= 1'b0;
            gnt_ld_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            rd_q        <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            // Acks are single-cycle pulses; only ACC raises one.
            cpu_ack_q <= 1'b0;
            ld_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_elig || ld_elig) begin
                        state_q     <= S_ACC;
                        gnt_ld_q    <= grant_ld_d;
                        last_ld_q   <= last_ld_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_ld_d ? ld_we    : cpu_we;
                        mem_addr_q  <= grant_ld_d ? ld_addr  : cpu_addr;
                        mem_wdata_q <= grant_ld_d ? ld_wdata : cpu_wdata;
                        rd_q        <= grant_ld_d ? ~ld_we   : ~cpu_we;
                    end
                end
                S_ACC: begin
                    // The RAM commits the write / launches the read at this edge.
                    state_q  <= S_RESP;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (gnt_ld_q) ld_ack_q  <= 1'b1;
                    else          cpu_ack_q <= 1'b1;
                end
                S_RESP: begin
                    // Requests are ignored here; capture read data for the owner.
                    state_q <= S_IDLE;
                    if (rd_q) begin
                        if (gnt_ld_q) ld_rdata_q  <= mem_rdata;
                        else          cpu_rdata_q <= mem_rdata;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // During the ack cycle of a read the RAM output is forwarded directly so
    // the requester sees its data together with the ack.
    assign cpu_rdata = (cpu_ack_q && rd_q) ? mem_rdata : cpu_rdata_q;
    assign ld_rdata  = (ld_ack_q  && rd_q) ? mem_rdata : ld_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign cpu_wait  = cpu_req & ~cpu_ack_q;
    assign gnt_ld    = gnt_ld_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, ld_req, ld_we, ld_lock;
    logic [7:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic [7:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
    logic       cpu_ack, cpu_wait, ld_ack, gnt_ld, mem_en, mem_we;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram [256];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack), .ld_lock(ld_lock), .gnt_ld(gnt_ld),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM: read data appears one cycle after the edge.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic       cr, cw;
        logic [7:0] ca;
        logic       lr, lw;
        logic [7:0] la, ld;
        logic       lk;
        logic       e_cack, e_lack;
        logic [7:0] e_crd, e_lrd;
        logic       e_gnt, e_en, e_we;
        logic [7:0] e_addr;
        logic       e_wait;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [7:0] ca,
                                input logic lr, input logic lw, input logic [7:0] la,
                                input logic [7:0] ld, input logic lk,
                                input logic e_cack, input logic e_lack,
                                input logic [7:0] e_crd, input logic [7:0] e_lrd,
                                input logic e_gnt, input logic e_en, input logic e_we,
                                input logic [7:0] e_addr, input logic e_wait);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
        v.lk = lk; v.e_cack = e_cack; v.e_lack = e_lack; v.e_crd = e_crd;
        v.e_lrd = e_lrd; v.e_gnt = e_gnt; v.e_en = e_en; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wait = e_wait;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_lock = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h0F] = 8'hA5;

        //            cr cw ca     lr lw la     ld     lk  cack lack crd    lrd    gnt en we addr   wait
        tbl[0]  = mk(1, 0, 8'h0F, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h0F, 1);
        tbl[1]  = mk(1, 0, 8'h0F, 0, 0, 8'h00, 8'h00, 0,  1, 0, 8'hA5, 8'h00, 0, 0, 0, 8'h0F, 0);
        tbl[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'hA5, 8'h00, 0, 0, 0, 8'h0F, 0);
        tbl[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'hA5, 8'h00, 0, 0, 0, 8'h0F, 0);
        tbl[4]  = mk(0, 0, 8'h00, 1, 1, 8'h20, 8'h3C, 0,  0, 0, 8'hA5, 8'h00, 1, 1, 1, 8'h20, 0);
        tbl[5]  = mk(0, 0, 8'h00, 1, 1, 8'h20, 8'h3C, 0,  0, 1, 8'hA5, 8'h00, 1, 0, 0, 8'h20, 0);
        tbl[6]  = mk(1, 0, 8'h20, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'hA5, 8'h00, 1, 0, 0, 8'h20, 1);
        tbl[7]  = mk(1, 0, 8'h20, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'hA5, 8'h00, 0, 1, 0, 8'h20, 1);
        tbl[8]  = mk(1, 0, 8'h20, 0, 0, 8'h00, 8'h00, 0,  1, 0, 8'h3C, 8'h00, 0, 0, 0, 8'h20, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h3C, 8'h00, 0, 0, 0, 8'h20, 0);
        tbl[10] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  0, 0, 8'h3C, 8'h00, 1, 1, 0, 8'h0F, 1);
        tbl[11] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  0, 1, 8'h3C, 8'hA5, 1, 0, 0, 8'h0F, 1);
        tbl[12] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  0, 0, 8'h3C, 8'hA5, 1, 0, 0, 8'h0F, 1);
        tbl[13] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  0, 0, 8'h3C, 8'hA5, 0, 1, 0, 8'h20, 1);
        tbl[14] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  1, 0, 8'h3C, 8'hA5, 0, 0, 0, 8'h20, 0);
        tbl[15] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  0, 0, 8'h3C, 8'hA5, 0, 0, 0, 8'h20, 1);
        tbl[16] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  0, 0, 8'h3C, 8'hA5, 1, 1, 0, 8'h0F, 1);
        tbl[17] = mk(1, 0, 8'h20, 1, 0, 8'h0F, 8'h00, 0,  0, 1, 8'h3C, 8'hA5, 1, 0, 0, 8'h0F, 1);
        tbl[18] = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h3C, 8'hA5, 1, 0, 0, 8'h0F, 0);

        // Reset values
        idle_inputs();
        rst = 1;
        step();
        step();
        chk("rst_mem_en",    mem_en,    0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_ack",   cpu_ack,   0);
        chk("rst_ld_ack",    ld_ack,    0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ld_rdata",  ld_rdata,  0);
        chk("rst_gnt_ld",    gnt_ld,    0);
        rst = 0;
        step();

        // Table: CPU read, loader write then CPU read, continuous tie
        for (int i = 0; i < 19; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = 8'h00;
            ld_req = tbl[i].lr; ld_we = tbl[i].lw; ld_addr = tbl[i].la; ld_wdata = tbl[i].ld;
            ld_lock = tbl[i].lk;
            step();
            chk($sformatf("v%0d_cpu_ack", i),   cpu_ack,   tbl[i].e_cack);
            chk($sformatf("v%0d_ld_ack", i),    ld_ack,    tbl[i].e_lack);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
            chk($sformatf("v%0d_ld_rdata", i),  ld_rdata,  tbl[i].e_lrd);
            chk($sformatf("v%0d_gnt_ld", i),    gnt_ld,    tbl[i].e_gnt);
            chk($sformatf("v%0d_mem_en", i),    mem_en,    tbl[i].e_en);
            chk($sformatf("v%0d_mem_we", i),    mem_we,    tbl[i].e_we);
            chk($sformatf("v%0d_mem_addr", i),  mem_addr,  tbl[i].e_addr);
            chk($sformatf("v%0d_cpu_wait", i),  cpu_wait,  tbl[i].e_wait);
            if (i == 4) chk("v4_mem_wdata", mem_wdata, 8'h3C);
        end

        // Loader lock holds off a waiting CPU request
        idle_inputs();
        ld_lock = 1; cpu_req = 1; cpu_addr = 8'h0F;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("lock_no_cpu_ack", cpu_ack, 0);
            chk("lock_no_mem_en",  mem_en,  0);
        end
        ld_lock = 0;
        step();
        chk("unlock_grant_en",  mem_en,  1);
        chk("unlock_grant_gnt", gnt_ld,  0);
        chk("unlock_ack_early", cpu_ack, 0);
        step();
        chk("unlock_ack",       cpu_ack,   1);
        chk("unlock_rdata",     cpu_rdata, 8'hA5);
        cpu_req = 0;
        step();
        chk("unlock_ack_end",   cpu_ack,   0);
        chk("unlock_rdata_hold", cpu_rdata, 8'hA5);

        // Reset asserted during ACC of a CPU read
        cpu_req = 1; cpu_addr = 8'h20;
        step();
        chk("rsta_acc_en", mem_en, 1);
        #2;
        rst = 1;
        #1;
        chk("rsta_mem_en",    mem_en,    0);
        chk("rsta_mem_addr",  mem_addr,  0);
        chk("rsta_cpu_rdata", cpu_rdata, 0);
        chk("rsta_ld_rdata",  ld_rdata,  0);
        chk("rsta_cpu_ack",   cpu_ack,   0);
        cpu_req = 0;
        step();
        chk("rsta_no_ack", cpu_ack, 0);
        rst = 0;
        cpu_req = 1;
        step();
        chk("rsta_post_en",  mem_en,  1);
        chk("rsta_post_ack0", cpu_ack, 0);
        step();
        chk("rsta_post_ack",   cpu_ack,   1);
        chk("rsta_post_rdata", cpu_rdata, 8'h3C);
        chk("rsta_post_ldack", ld_ack,    0);
        cpu_req = 0;
        step();
        chk("rsta_post_hold", cpu_rdata, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port synchronous program/data RAM between two requesters: the CPU sequencer (microcode memory-address and memory-out/in steps) and the program loader/debug port. Each access uses a request/acknowledge handshake. A three-state FSM serialises accesses, with round-robin tie-breaking and a loader lock. The CPU sequencer freezes its step counter on `cpu_wait`.

## Interface
- `ADDR_W`, default 8: RAM address width.
- `DATA_W`, default 8: RAM data width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  ADDR_W  CPU address; stable while `cpu_req` is high.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  CPU read data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_wait`  out  1  `cpu_req & ~cpu_ack` (combinational); the sequencer stalls on it.
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`, `ld_rdata`, `ld_ack`: loader port with the same directions, widths and rules as the CPU port.
- `ld_lock`  in  1  while high, CPU requests are never granted.
- `gnt_ld`  out  1  owner of the current/last access (1 = loader).
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after an enabled read edge.

## Operation
- FSM states: IDLE, ACC, RESP. Reset state is IDLE.
- **IDLE**
  - Evaluates eligible requests: `ld_req`, and `cpu_req & ~ld_lock`.
  - With one eligible request, grant it.
  - With two eligible requests, grant the port not granted last. The `last_ld` pointer resets to 0, so the loader wins the first tie.
  - On grant, latch the winner's we/addr/wdata into the mem output registers, set `gnt_ld`, update `last_ld`, and go to ACC.
- **ACC**
  - `mem_en=1`, with `mem_we`, `mem_addr` and `mem_wdata` from the latches.
  - A write commits at the closing edge. A read launches at the closing edge.
  - Always go to RESP.
- **RESP**
  - `mem_en=0`, `mem_we=0`.
  - Pulse the owner's ack.
  - For a read, the owner's rdata shows `mem_rdata` this cycle and a register captures it at the closing edge. The rdata output holds that value until the owner's next completed read. Writes never change rdata.
  - Requests are ignored in RESP. Always go to IDLE.
- A requester must deassert req, or present a new request, in the cycle after ack. A req still high in IDLE is a new access.
- If `ld_lock` rises while a CPU access is in ACC or RESP, that access completes normally. The lock only affects grants.
- Non-owner outputs are unaffected by an access; the non-owner's ack stays 0.

## Timing
- Reset values:
  - state IDLE, `last_ld=0`, `gnt_ld=0`
  - `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`
  - `cpu_ack=0`, `ld_ack=0`, `cpu_rdata=0`, `ld_rdata=0`
- Latency: req high in IDLE at edge E0 → ACC during E0..E1 → ack high during E1..E2 → IDLE from E2.
- Request to ack is 2 cycles. Minimum spacing is 3 cycles per access (ACC, RESP, IDLE).
- Worst-case CPU wait with a continuously requesting loader and `ld_lock=0` is 5 cycles (one loader access, then the CPU access). Round robin guarantees no starvation.
- Reset asserted mid-access:
  - State and outputs clear immediately, asynchronously.
  - An in-flight write may or may not have committed.
  - No ack is issued; the requester reissues after reset.
- Address and data widths pass through unmodified. There is no address wrap or arithmetic in this block.

## Configuration
- Macro `MEM_ARB_LD_PRIORITY_EN`.
- Defined: fixed priority. The loader wins every tie, and `last_ld` is unused (held 0). The CPU can starve while the loader streams.
- Undefined: round-robin tie-break as described in Operation.

## Test plan
- Reset, then CPU read of addr 0x0F with RAM[0x0F]=0xA5: `cpu_ack` 2 cycles after req, `cpu_rdata=0xA5` during ack and held after; `ld_ack` stays 0.
- Loader writes 0x3C to 0x20, then the CPU reads 0x20: `mem_we` high for exactly one cycle in ACC; the CPU reads 0x3C; `cpu_wait` high from req until ack.
- Both requesters raise req in the same cycle and hold it continuously: grants alternate loader, CPU, loader, CPU, with 3 cycles between acks (macro undefined). With the macro defined, only the loader is granted.
- `ld_lock=1`, `cpu_req` held: no `cpu_ack` for 20 cycles. Drop the lock: `cpu_ack` 2 cycles later.
- `rst` pulsed during ACC of a CPU read: all outputs return to reset values asynchronously, no ack is issued, and the next request is served normally.
